// File: rtl/disp_pkg.sv
// disp_pkg: shared encodings, constants, scan state and digit-to-field mapping for the display scanner
package disp_pkg;
  localparam logic [1:0] MODE_CLOCK = 2'b00;
  localparam logic [1:0] MODE_TSET  = 2'b01;
  localparam logic [1:0] MODE_ASET  = 2'b10;
  localparam logic [1:0] POS_SEC    = 2'b00;
  localparam logic [1:0] POS_MIN    = 2'b01;
  localparam logic [1:0] POS_HOUR   = 2'b10;
  localparam logic [1:0] POS_NONE   = 2'b11;
  localparam logic [6:0] SEG_BLANK  = 7'b0;
  localparam logic [5:0] ENB_ALL_OFF = 6'b111111;
  typedef enum logic {S_GUARD, S_ON} state_e;
  function automatic logic [1:0] digit_field(input logic [2:0] idx);
    return idx[2:1];
  endfunction
endpackage

// File: rtl/disp_blink_gen.sv
// disp_blink_gen: restartable blink phase; ports clk, rst, restart in, blink_on out (1 after reset/restart)
module disp_blink_gen #(
  parameter int BLINK_HALF = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic blink_on
);
  localparam int W = $clog2(BLINK_HALF + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_q    <= '0;
      blink_on <= 1'b1;
    end else if (cnt_q == W'(BLINK_HALF - 1)) begin
      cnt_q    <= '0;
      blink_on <= ~blink_on;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/disp_scan_sched.sv
// disp_scan_sched: six-digit scan with guard gaps and field blink; digit bus/dp/mode/position in, registered seg/dp/active-low enables out
module disp_scan_sched
  import disp_pkg::*;
#(
  parameter int SCAN_DIV   = 5000,
  parameter int GUARD_CYC  = 2,
  parameter int BLINK_HALF = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [41:0] i_six_digit_seg,
  input  logic [5:0]  i_six_dp,
  input  logic [1:0]  i_mode,
  input  logic [1:0]  i_position,
  output logic [6:0]  o_seg,
  output logic        o_seg_dp,
  output logic [5:0]  o_seg_enb
);
  localparam int CW = $clog2((SCAN_DIV > GUARD_CYC ? SCAN_DIV : GUARD_CYC) + 1);
  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, pos_q;
  logic          last, blank, restart, blink_on, dp_d;
  logic [6:0]    seg_d;
  logic [5:0]    enb_d;
  // previous mode/position load even during reset so release never triggers a restart
  always_ff @(posedge clk) begin
    mode_q <= i_mode;
    pos_q  <= i_position;
  end
  assign restart = (i_mode != mode_q) || (i_position != pos_q);
  disp_blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .blink_on (blink_on)
  );
  // one counter serves both the guard and the lit interval
  always_comb begin
    last    = (state_q == S_GUARD) ? (cnt_q == CW'(GUARD_CYC - 1)) : (cnt_q == CW'(SCAN_DIV - 1));
    state_d = last ? ((state_q == S_GUARD) ? S_ON : S_GUARD) : state_q;
    cnt_d   = last ? '0 : cnt_q + 1'b1;
    idx_d   = (last && state_q == S_ON) ? ((idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1) : idx_q;
    blank   = (i_mode == MODE_TSET || i_mode == MODE_ASET) && i_position != POS_NONE &&
              !blink_on && digit_field(idx_q) == i_position;
    enb_d   = (state_q == S_ON) ? ~(6'd1 << idx_q) : ENB_ALL_OFF;
    seg_d   = (state_q == S_ON && !blank) ? i_six_digit_seg[7*idx_q +: 7] : SEG_BLANK;
    dp_d    = state_q == S_ON && !blank && i_six_dp[idx_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_GUARD;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      o_seg     <= SEG_BLANK;
      o_seg_dp  <= 1'b0;
      o_seg_enb <= ENB_ALL_OFF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      o_seg     <= seg_d;
      o_seg_dp  <= dp_d;
      o_seg_enb <= enb_d;
    end
  end
endmodule
